alu_issue_unit: RTL and testbench



---
 rtl/alu_issue_unit.sv | 197 +++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//   Issue/writeback stage around a one-cycle-latency ALU. It accepts one
//   instruction at a time and reads operands from a 16 x 32 register file.
//   It drives the ALU inputs and writes the ALU result back. Load-immediate
//   (funct 0) bypasses the ALU. Function codes 10-15 set a sticky error flag.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   instr_valid     instruction word present
//   instr[31:0]     {funct, rd, rs, rt, shamt/imm}
//   instr_ready     block is idle and can accept an instruction
//   alu_a/b[31:0]   ALU operands
//   alu_shamt[4:0]  ALU shift amount
//   alu_funct[3:0]  ALU function code
//   alu_res[31:0]   ALU result (registered inside the ALU)
//   wb_valid        one-cycle pulse per register writeback
//   wb_addr[3:0]    destination of that writeback
//   wb_data[31:0]   value written
//   err             sticky illegal-funct flag
//   dbg_addr[3:0]   debug read address
//   dbg_data[31:0]  combinational read of R[dbg_addr]
// ---------------------------------------------------------------------------
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_funct,
  input  logic [31:0] alu_res,
  output logic        wb_valid,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_LDI  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [3:0]  alu_funct_q, alu_funct_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf [16];

  // Instruction fields
  logic [3:0]  in_funct;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;

  assign in_funct = instr[31:28];
  assign in_rd    = instr[27:24];
  assign in_rs    = instr[23:20];
  assign in_rt    = instr[19:16];
  assign in_shamt = instr[15:11];
  assign in_imm   = instr[15:0];

  // Register file. R0 is hard-wired to zero, so only R1-R15 hold state.
  // Flops rather than RAM: every entry must clear on reset.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_reg
        logic [31:0] r_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_q <= '0;
          end else if (rf_we && (rd_q == 4'(gi))) begin
            r_q <= rf_wdata;
          end
        end
        assign rf[gi] = r_q;
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_shamt_d = alu_shamt_q;
    alu_funct_d = alu_funct_q;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    err_d       = err_q;
    rf_we       = 1'b0;
    rf_wdata    = alu_res;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (in_funct == 4'd0) begin
            rd_d    = in_rd;
            imm_d   = {{16{in_imm[15]}}, in_imm};
            state_d = S_LDI;
          end else if (in_funct <= 4'd9) begin
            alu_a_d     = rf[in_rs];
            alu_b_d     = rf[in_rt];
            alu_shamt_d = in_shamt;
            alu_funct_d = in_funct;
            rd_d        = in_rd;
            state_d     = S_EXEC;
          end else begin
            // Illegal code: flag it and stay ready; ALU inputs untouched.
            err_d = 1'b1;
          end
        end
      end
      // The ALU registers its result on the EXEC->WB edge.
      S_EXEC: state_d = S_WB;
      S_WB: begin
        rf_we      = 1'b1;
        rf_wdata   = alu_res;
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = alu_res;
        state_d    = S_IDLE;
      end
      S_LDI: begin
        rf_we      = 1'b1;
        rf_wdata   = imm_q;
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = imm_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_shamt_q <= '0;
      alu_funct_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_shamt_q <= alu_shamt_d;
      alu_funct_q <= alu_funct_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_shamt   = alu_shamt_q;
  assign alu_funct   = alu_funct_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign err         = err_q;
  assign dbg_data    = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;
  logic [31:0] alu_res;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_shamt   (alu_shamt),
    .alu_funct   (alu_funct),
    .alu_res     (alu_res),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU with one-cycle registered latency: 1 = ADD, 8 = SRA.
  always @(posedge clk) begin
    case (alu_funct)
      4'd1:    alu_res <= alu_a + alu_b;
      4'd8:    alu_res <= $signed(alu_a) >>> alu_shamt;
      default: alu_res <= 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          lat;     // edges from accept to wb_valid; 0 = no writeback
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  funct;
    logic        err;
    logic [3:0]  dbg_a;
    logic [31:0] dbg_d;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int g;
    int pulses;
    int seen;
    logic [3:0]  cap_addr;
    logic [31:0] cap_data;
    g = 0;
    @(negedge clk);
    while (!instr_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = v.instr;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    chk("alu_a", alu_a, v.a);
    chk("alu_b", alu_b, v.b);
    chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, v.shamt});
    chk("alu_funct", {28'd0, alu_funct}, {28'd0, v.funct});
    chk("err", {31'd0, err}, {31'd0, v.err});
    pulses   = 0;
    seen     = 0;
    cap_addr = '0;
    cap_data = '0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      chk("instr_ready", {31'd0, instr_ready}, (c >= v.lat) ? 32'd1 : 32'd0);
      if (wb_valid) begin
        pulses++;
        if (seen == 0) begin
          seen     = c;
          cap_addr = wb_addr;
          cap_data = wb_data;
        end
      end
    end
    chk("wb_latency", 32'(seen), 32'(v.lat));
    chk("wb_pulses", 32'(pulses), (v.lat > 0) ? 32'd1 : 32'd0);
    if (v.lat > 0) begin
      chk("wb_addr", {28'd0, cap_addr}, {28'd0, v.addr});
      chk("wb_data", cap_data, v.data);
    end
    dbg_addr = v.dbg_a;
    #1;
    chk("dbg_data", dbg_data, v.dbg_d);
    $display("instr=0x%08h lat=%0d wb_addr=%0d wb_data=0x%08h err=%0b dbg[%0d]=0x%08h",
             v.instr, seen, cap_addr, cap_data, err, v.dbg_a, dbg_data);
  endtask

  task automatic check_all_regs_zero(input string name);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      chk(name, dbg_data, 32'd0);
    end
  endtask

  initial begin
    //            instr         lat addr  data          a             b             sh  fn  err dbg dbg_d
    vecs[0] = '{32'h0100_0005, 1, 4'd1, 32'h0000_0005, 32'h0,        32'h0,        5'd0, 4'd0, 1'b0, 4'd1, 32'h0000_0005};
    vecs[1] = '{32'h0200_0007, 1, 4'd2, 32'h0000_0007, 32'h0,        32'h0,        5'd0, 4'd0, 1'b0, 4'd2, 32'h0000_0007};
    vecs[2] = '{32'h1312_0000, 2, 4'd3, 32'h0000_000C, 32'h5,        32'h7,        5'd0, 4'd1, 1'b0, 4'd3, 32'h0000_000C};
    vecs[3] = '{32'h0100_8000, 1, 4'd1, 32'hFFFF_8000, 32'h5,        32'h7,        5'd0, 4'd1, 1'b0, 4'd1, 32'hFFFF_8000};
    vecs[4] = '{32'h8410_2000, 2, 4'd4, 32'hFFFF_F800, 32'hFFFF_8000, 32'h0,       5'd4, 4'd8, 1'b0, 4'd4, 32'hFFFF_F800};
    vecs[5] = '{32'h0000_0009, 1, 4'd0, 32'h0000_0009, 32'hFFFF_8000, 32'h0,       5'd4, 4'd8, 1'b0, 4'd0, 32'h0000_0000};
    vecs[6] = '{32'hA000_0000, 0, 4'd0, 32'h0000_0000, 32'hFFFF_8000, 32'h0,       5'd4, 4'd8, 1'b1, 4'd4, 32'hFFFF_F800};
    vecs[7] = '{32'h1534_0000, 2, 4'd5, 32'hFFFF_F80C, 32'h0000_000C, 32'hFFFF_F800, 5'd0, 4'd1, 1'b1, 4'd5, 32'hFFFF_F80C};

    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_shamt", {27'd0, alu_shamt}, 32'd0);
    chk("rst_alu_funct", {28'd0, alu_funct}, 32'd0);
    check_all_regs_zero("rst_regfile");

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset mid-operation: ADD accepted, reset asserted while in EXEC.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 32'h1312_0000;
    @(posedge clk);
    #1;
    chk("midrst_in_exec_ready", {31'd0, instr_ready}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_alu_funct", {28'd0, alu_funct}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    check_all_regs_zero("midrst_regfile");
    // instr_valid still high while reset holds: nothing may be accepted.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("midrst_hold_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("midrst_hold_alu_funct", {28'd0, alu_funct}, 32'd0);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    check_all_regs_zero("postrst_regfile");
    $display("reset mid-op: abandoned, regs cleared, err=%0b", err);

    begin
      vec_t v;
      v = '{32'h0600_0033, 1, 4'd6, 32'h0000_0033, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 4'd6, 32'h0000_0033};
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
